// File: rtl/pool_window_buffer.sv
// Streaming 2x2 stride-2 window assembler feeding the average-pooling unit.
// One line buffer holds the even row; the odd row's left pixel is held in a register.
module pool_window_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_WIDTH   = 28,
    parameter int IN_HEIGHT  = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] win_a,
    output logic [DATA_WIDTH-1:0] win_b,
    output logic [DATA_WIDTH-1:0] win_c,
    output logic [DATA_WIDTH-1:0] win_d,
    output logic                  frame_done
);

    localparam int COL_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IN_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_WIN_LAST = COL_W'(2 * (IN_WIDTH / 2) - 1);
    localparam logic [ROW_W-1:0] ROW_WIN_LAST = ROW_W'(2 * (IN_HEIGHT / 2) - 1);

    logic [COL_W-1:0]      colReg, colNext;
    logic [ROW_W-1:0]      rowReg, rowNext;
    logic                  accept;
    logic                  lastCol, lastRow;
    logic                  rowOdd, colOdd;
    logic                  trigger;
    logic [COL_W-1:0]      readIdxRight;

    logic [DATA_WIDTH-1:0] lineBuf [IN_WIDTH];
    logic [DATA_WIDTH-1:0] topLeftReg, topRightReg;
    logic [DATA_WIDTH-1:0] holdReg;

    logic                  outValidReg;
    logic                  frameDoneReg;
    logic [DATA_WIDTH-1:0] winReg [4];
    logic [DATA_WIDTH-1:0] winSrc [4];

    assign in_ready = !reset && (!outValidReg || out_ready);
    assign accept   = in_valid && in_ready;

    assign lastCol = (colReg == COL_LAST);
    assign lastRow = (rowReg == ROW_LAST);
    assign rowOdd  = rowReg[0];
    assign colOdd  = colReg[0];

    assign trigger = accept && rowOdd && colOdd &&
                     (rowReg <= ROW_WIN_LAST) && (colReg <= COL_WIN_LAST);

    always_comb begin
        colNext = colReg;
        rowNext = rowReg;
        if (accept) begin
            if (lastCol) begin
                colNext = '0;
                rowNext = lastRow ? '0 : rowReg + ROW_W'(1);
            end else begin
                colNext = colReg + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            colReg <= '0;
            rowReg <= '0;
        end else begin
            colReg <= colNext;
            rowReg <= rowNext;
        end
    end

    // The trailing column of an odd width has no right neighbour; clamp keeps the read in range.
    assign readIdxRight = lastCol ? colReg : colReg + COL_W'(1);

    // Top-row pair is fetched when the bottom-left pixel arrives, so it is ready one
    // transfer later for the bottom-right trigger. Odd rows never write the buffer.
    always_ff @(posedge clk) begin
        if (accept && !rowOdd) begin
            lineBuf[colReg] <= in_data;
        end
        if (accept && rowOdd && !colOdd) begin
            topLeftReg  <= lineBuf[colReg];
            topRightReg <= lineBuf[readIdxRight];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            holdReg <= '0;
        end else if (accept && rowOdd && !colOdd) begin
            holdReg <= in_data;
        end
    end

    assign winSrc[0] = topLeftReg;
    assign winSrc[1] = topRightReg;
    assign winSrc[2] = holdReg;
    assign winSrc[3] = in_data;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_win
            always_ff @(posedge clk) begin
                if (reset) begin
                    winReg[gi] <= '0;
                end else if (trigger) begin
                    winReg[gi] <= winSrc[gi];
                end
            end
        end
    endgenerate

    // A trigger can only coincide with an output transfer, never overwrite a stalled window.
    always_ff @(posedge clk) begin
        if (reset) begin
            outValidReg <= 1'b0;
        end else if (trigger) begin
            outValidReg <= 1'b1;
        end else if (out_ready) begin
            outValidReg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frameDoneReg <= 1'b0;
        end else begin
            frameDoneReg <= accept && lastCol && lastRow;
        end
    end

    assign out_valid  = outValidReg;
    assign frame_done = frameDoneReg;
    assign win_a      = winReg[0];
    assign win_b      = winReg[1];
    assign win_c      = winReg[2];
    assign win_d      = winReg[3];

endmodule

// File: tb/tb_pool_window_buffer.sv
// Bench for pool_window_buffer: three instances (4x4, 5x5, 28x28) checked every cycle
// against a frame-array model, plus literal window expectations.
module tb_pool_window_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst      [3];
    logic        inValid  [3];
    logic [15:0] inData   [3];
    logic        inReady  [3];
    bit          randReady[3];
    bit          stallArm [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_inst
            localparam int W = (gi == 0) ? 4 : (gi == 1) ? 5 : 28;
            localparam int H = (gi == 0) ? 4 : (gi == 1) ? 5 : 28;
            localparam int N = W * H;

            logic        rdy;
            logic        outV;
            logic        fDone;
            logic [15:0] wa, wb, wc, wd;
            logic [63:0] winLog[$];
            int          doneCount = 0;

            pool_window_buffer #(
                .DATA_WIDTH(16),
                .IN_WIDTH  (W),
                .IN_HEIGHT (H)
            ) dut (
                .clk       (clk),
                .reset     (rst[gi]),
                .in_valid  (inValid[gi]),
                .in_ready  (inReady[gi]),
                .in_data   (inData[gi]),
                .out_valid (outV),
                .out_ready (rdy),
                .win_a     (wa),
                .win_b     (wb),
                .win_c     (wc),
                .win_d     (wd),
                .frame_done(fDone)
            );

            // Model: pixels land in a frame array by raster position; a window is due
            // when the bottom-right pixel of a complete 2x2 block is accepted.
            logic [15:0] frame [N];
            int          pos    = 0;
            bit          mValid = 1'b0;
            logic [63:0] mWin   = '0;
            bit          mDone  = 1'b0;
            bit          mReadyP;
            int          r, c;

            initial forever begin
                @(posedge clk);
                mReadyP = !rst[gi] && (!mValid || rdy);
                if (rst[gi]) begin
                    mValid = 1'b0;
                    mDone  = 1'b0;
                    pos    = 0;
                end else begin
                    mDone = 1'b0;
                    if (mValid && rdy) mValid = 1'b0;
                    if (inValid[gi] && mReadyP) begin
                        r = pos / W;
                        c = pos % W;
                        frame[pos] = inData[gi];
                        if (r % 2 == 1 && c % 2 == 1 && r < 2 * (H / 2) && c < 2 * (W / 2)) begin
                            mWin   = {frame[pos-W-1], frame[pos-W], frame[pos-1], inData[gi]};
                            mValid = 1'b1;
                        end
                        if (pos == N - 1) begin
                            mDone = 1'b1;
                            pos   = 0;
                        end else begin
                            pos++;
                        end
                    end
                end
            end

            bit mReadyN;
            initial forever begin
                @(negedge clk);
                mReadyN = !rst[gi] && (!mValid || rdy);
                check($sformatf("in_ready[%0d]", gi), 64'(inReady[gi]), 64'(mReadyN));
                check($sformatf("out_valid[%0d]", gi), 64'(outV), 64'(mValid));
                check($sformatf("frame_done[%0d]", gi), 64'(fDone), 64'(mDone));
                if (mValid)
                    check($sformatf("window[%0d]", gi), {wa, wb, wc, wd}, mWin);
                if (outV && rdy) winLog.push_back({wa, wb, wc, wd});
                if (fDone) doneCount++;
            end

            // Output-ready driver: optional one-shot 5-cycle stall on the first window seen.
            int stallLeft = 0;
            bit stallUsed = 1'b0;
            initial begin
                rdy = 1'b1;
                forever begin
                    @(posedge clk);
                    #1;
                    if (stallLeft > 0) begin
                        rdy = 1'b0;
                        stallLeft--;
                    end else if (stallArm[gi] && !stallUsed && outV) begin
                        stallUsed = 1'b1;
                        stallLeft = 4;
                        rdy       = 1'b0;
                    end else begin
                        rdy = randReady[gi] ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                end
            end
        end
    endgenerate

    task automatic sendPixel(input int k, input logic [15:0] d, input bit rv);
        int guard;
        bit acc;
        guard = 0;
        acc   = 1'b0;
        inData[k] = d;
        while (!acc) begin
            inValid[k] = rv ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = inValid[k] && inReady[k];
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 1000) begin
                total++;
                bad++;
                $display("FAIL accept_timeout inst=%0d actual=no_accept required=accept", k);
                return;
            end
        end
    endtask

    task automatic sendFrame(input int k, input int base, input int n, input bit rv);
        for (int i = 0; i < n; i++) sendPixel(k, 16'(base + i), rv);
    endtask

    task automatic idle(input int k, input int n);
        inValid[k] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [63:0] basicWin [4];
    logic [63:0] oddWin   [4];

    initial begin
        basicWin[0] = 64'h0000_0001_0004_0005;
        basicWin[1] = 64'h0002_0003_0006_0007;
        basicWin[2] = 64'h0008_0009_000C_000D;
        basicWin[3] = 64'h000A_000B_000E_000F;
        oddWin[0]   = 64'h0000_0001_0005_0006;
        oddWin[1]   = 64'h0002_0003_0007_0008;
        oddWin[2]   = 64'h000A_000B_000F_0010;
        oddWin[3]   = 64'h000C_000D_0011_0012;

        for (int k = 0; k < 3; k++) begin
            rst[k]       = 1'b1;
            inValid[k]   = 1'b0;
            inData[k]    = '0;
            randReady[k] = 1'b0;
            stallArm[k]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 64'(g_inst[0].outV), 64'd0);
        check("reset windows", {g_inst[0].wa, g_inst[0].wb, g_inst[0].wc, g_inst[0].wd}, 64'd0);
        check("reset in_ready", 64'(inReady[0]), 64'd0);
        check("reset frame_done", 64'(g_inst[0].fDone), 64'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // 4x4 basic
        sendFrame(0, 0, 16, 1'b0);
        idle(0, 8);
        for (int i = 0; i < 4; i++)
            check($sformatf("basic win%0d", i), g_inst[0].winLog[i], basicWin[i]);
        check("basic frame_done count", 64'(g_inst[0].doneCount), 64'd1);

        // 4x4 with 5-cycle stall on the first window
        stallArm[0] = 1'b1;
        sendFrame(0, 0, 16, 1'b0);
        idle(0, 12);
        stallArm[0] = 1'b0;
        for (int i = 0; i < 4; i++)
            check($sformatf("stall win%0d", i), g_inst[0].winLog[4+i], basicWin[i]);

        // back-to-back frames, second offset by 0x100
        sendFrame(0, 0, 16, 1'b0);
        sendFrame(0, 16'h0100, 16, 1'b0);
        idle(0, 8);
        check("b2b win0", g_inst[0].winLog[8], basicWin[0]);
        check("b2b win4", g_inst[0].winLog[12], 64'h0100_0101_0104_0105);
        check("b2b win7", g_inst[0].winLog[15], 64'h010A_010B_010E_010F);
        check("b2b frame_done count", 64'(g_inst[0].doneCount), 64'd4);

        // reset after p6, then a fresh frame
        sendFrame(0, 0, 7, 1'b0);
        inValid[0] = 1'b0;
        rst[0]     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset out_valid", 64'(g_inst[0].outV), 64'd0);
        check("midreset windows", {g_inst[0].wa, g_inst[0].wb, g_inst[0].wc, g_inst[0].wd}, 64'd0);
        check("midreset in_ready", 64'(inReady[0]), 64'd0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        sendFrame(0, 0, 16, 1'b0);
        idle(0, 8);
        check("midreset partial win", g_inst[0].winLog[16], basicWin[0]);
        for (int i = 0; i < 4; i++)
            check($sformatf("postreset win%0d", i), g_inst[0].winLog[17+i], basicWin[i]);
        check("inst0 window count", 64'(g_inst[0].winLog.size()), 64'd21);
        check("inst0 frame_done count", 64'(g_inst[0].doneCount), 64'd5);

        // 5x5 floor pooling
        sendFrame(1, 0, 25, 1'b0);
        idle(1, 8);
        for (int i = 0; i < 4; i++)
            check($sformatf("odd win%0d", i), g_inst[1].winLog[i], oddWin[i]);
        check("odd window count", 64'(g_inst[1].winLog.size()), 64'd4);
        check("odd frame_done count", 64'(g_inst[1].doneCount), 64'd1);

        // 28x28 with random valid/ready
        randReady[2] = 1'b1;
        sendFrame(2, 16'h1000, 784, 1'b1);
        idle(2, 40);
        randReady[2] = 1'b0;
        idle(2, 4);
        check("rand first win", g_inst[2].winLog[0], 64'h1000_1001_101C_101D);
        check("rand window count", 64'(g_inst[2].winLog.size()), 64'd196);
        check("rand frame_done count", 64'(g_inst[2].doneCount), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
